// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: parametrised valid/ready pipeline register.
// Carries N-bit data through STAGES register stages. Each stage has its own
// valid bit, and empty stages collapse under a downstream stall.
// A synchronous flush drops in-flight data. Reset is synchronous and has
// priority over flush.
// Optional feature: define REG_PIPE_OCC_EN to add the registered `occupancy`
// output (count of valid stages).
module reg_pipe_hs #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    // Per-stage valid bits and data registers
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [N-1:0]      data_q [STAGES];

    // Combinational helpers: ready chain, incoming valid/data, load enables
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] inc_vld;
    logic [STAGES-1:0] load;
    logic [N-1:0]      src [STAGES];

    // Ready chain from the output stage back to the input stage; a stage is ready when empty or when its successor is ready
    always_comb begin
        logic r;
        rdy = '0;
        r   = ~vld_q[STAGES-1] | out_ready;
        rdy[STAGES-1] = r;
        for (int k = STAGES - 2; k >= 0; k--) begin
            r      = ~vld_q[k] | r;
            rdy[k] = r;
        end
    end

    // Valid and data presented to each stage by its predecessor (the producer for stage 0)
    always_comb begin
        inc_vld    = '0;
        src[0]     = in_data;
        inc_vld[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            inc_vld[k] = vld_q[k-1];
            src[k]     = data_q[k-1];
        end
    end

    // Next-state valids and data load enables; flush empties every stage and freezes the data
    always_comb begin
        vld_d = vld_q;
        load  = '0;
        if (flush) begin
            vld_d = '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_d[k] = inc_vld[k];
                    load[k]  = inc_vld[k];
                end
            end
        end
    end

    // Valid register per stage
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Data registers load only on a real incoming word, so bubbles leave them untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    data_q[k] <= src[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = $clog2(STAGES + 1);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    // Occupancy next state is the population count of the next-state valids
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OW'(vld_d[k]);
        end
    end

    // Occupancy register updates on the same edge as the valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Directed bench for reg_pipe_hs. It drives a STAGES=2 instance and a STAGES=3
// instance from one clock and one reset. Occupancy is checked only when
// REG_PIPE_OCC_EN is defined.
module tb_reg_pipe_hs;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       fl2, iv2, ir2, ov2, or2;
    logic [7:0] id2, od2;
    logic       fl3, iv3, ir3, ov3, or3;
    logic [7:0] id3, od3;
`ifdef REG_PIPE_OCC_EN
    logic [1:0] oc2, oc3;
`endif

    reg_pipe_hs #(.N(8), .STAGES(2)) u2 (
        .clock(clock), .reset(reset), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef REG_PIPE_OCC_EN
        , .occupancy(oc2)
`endif
    );

    reg_pipe_hs #(.N(8), .STAGES(3)) u3 (
        .clock(clock), .reset(reset), .flush(fl3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3)
`ifdef REG_PIPE_OCC_EN
        , .occupancy(oc3)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic occ2(input string tag, input logic [31:0] exp);
`ifdef REG_PIPE_OCC_EN
        chk(tag, 32'(oc2), exp);
`endif
    endtask

    task automatic occ3(input string tag, input logic [31:0] exp);
`ifdef REG_PIPE_OCC_EN
        chk(tag, 32'(oc3), exp);
`endif
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; id2 = 8'h00;
        fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = 8'h00;
        cyc(); cyc();

        // Fill the STAGES=2 pipe with 0xA5, then reset it
        reset = 1'b0; iv2 = 1'b1; id2 = 8'hA5;
        settle(); chk("fill_rdy0", 32'(ir2), 1);
        cyc();
        settle(); chk("fill_rdy1", 32'(ir2), 1);
        cyc();
        settle();
        chk("full_ov", 32'(ov2), 1);
        chk("full_od", 32'(od2), 32'hA5);
        chk("full_ir", 32'(ir2), 0);
        occ2("full_occ", 2);
        reset = 1'b1; iv2 = 1'b0;
        cyc();
        reset = 1'b0;
        settle();
        chk("rst_ov", 32'(ov2), 0);
        chk("rst_od", 32'(od2), 0);
        chk("rst_ir", 32'(ir2), 1);
        occ2("rst_occ", 0);
        chk("rst_ov3", 32'(ov3), 0);

        // Streaming 0x01..0x10 with out_ready held high
        or2 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            iv2 = (c < 16);
            id2 = 8'(c + 1);
            settle();
            chk("str_ir", 32'(ir2), 1);
            chk("str_ov", 32'(ov2), (c >= 2) ? 1 : 0);
            if (c >= 2) chk("str_od", 32'(od2), 32'(c - 1));
            cyc();
        end
        iv2 = 1'b0;
        settle(); chk("str_end_ov", 32'(ov2), 0);
        cyc();

        // Back-pressure: 0x11, 0x22 held, then released
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h11;
        cyc();
        id2 = 8'h22;
        settle(); chk("bp_rdy_fill", 32'(ir2), 1);
        cyc();
        id2 = 8'h33;
        settle();
        chk("bp_ir0", 32'(ir2), 0);
        chk("bp_ov0", 32'(ov2), 1);
        chk("bp_od0", 32'(od2), 32'h11);
        cyc();
        settle();
        chk("bp_ir1", 32'(ir2), 0);
        chk("bp_od1", 32'(od2), 32'h11);
        occ2("bp_occ", 2);
        or2 = 1'b1;
        settle();
        chk("bp_rel_ir", 32'(ir2), 1);
        chk("bp_rel_od", 32'(od2), 32'h11);
        cyc();
        iv2 = 1'b0;
        settle(); chk("bp_od_22", 32'(od2), 32'h22);
        cyc();
        settle(); chk("bp_od_33", 32'(od2), 32'h33);
        cyc();
        settle(); chk("bp_end_ov", 32'(ov2), 0);

        // Flush with 0x44 in the output stage and 0x33 behind it
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h44;
        cyc();
        id2 = 8'h33;
        cyc();
        or2 = 1'b1; fl2 = 1'b1; id2 = 8'h77;
        settle();
        chk("fl_ir", 32'(ir2), 0);
        chk("fl_ov", 32'(ov2), 1);
        chk("fl_od", 32'(od2), 32'h44);
        cyc();
        fl2 = 1'b0; iv2 = 1'b0;
        settle();
        chk("fl_after_ov", 32'(ov2), 0);
        chk("fl_after_od", 32'(od2), 32'h44);
        chk("fl_after_ir", 32'(ir2), 1);
        occ2("fl_after_occ", 0);
        cyc();
        settle(); chk("fl_no77_ov", 32'(ov2), 0);

        // Full pipe with simultaneous input and output transfers
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h80;
        cyc();
        id2 = 8'h81;
        cyc();
        settle(); chk("sim_full_ir", 32'(ir2), 0);
        for (int i = 0; i < 10; i++) begin
            iv2 = 1'b1; or2 = 1'b1; id2 = 8'(8'h82 + i);
            settle();
            chk("sim_ir", 32'(ir2), 1);
            chk("sim_ov", 32'(ov2), 1);
            chk("sim_od", 32'(od2), 32'(8'h80 + i));
            occ2("sim_occ", 2);
            cyc();
        end
        iv2 = 1'b0;
        settle(); chk("sim_drain0", 32'(od2), 32'h8A);
        cyc();
        settle(); chk("sim_drain1", 32'(od2), 32'h8B);
        cyc();
        settle(); chk("sim_drain_ov", 32'(ov2), 0);

        // Bubble collapse on the STAGES=3 pipe with out_ready low
        or3 = 1'b0; iv3 = 1'b1; id3 = 8'h5A;
        cyc();
        iv3 = 1'b0;
        settle(); chk("bub_ir_a", 32'(ir3), 1); occ3("bub_occ_a", 1);
        cyc();
        settle(); chk("bub_ov_b", 32'(ov3), 0); occ3("bub_occ_b", 1);
        cyc();
        iv3 = 1'b1; id3 = 8'h61;
        settle();
        chk("bub_ov_c", 32'(ov3), 1);
        chk("bub_od_c", 32'(od3), 32'h5A);
        chk("bub_ir_c", 32'(ir3), 1);
        occ3("bub_occ_c", 1);
        cyc();
        id3 = 8'h62;
        settle(); chk("bub_ir_d", 32'(ir3), 1); occ3("bub_occ_d", 2);
        cyc();
        id3 = 8'h63;
        settle();
        chk("bub_ir_full", 32'(ir3), 0);
        chk("bub_od_full", 32'(od3), 32'h5A);
        occ3("bub_occ_full", 3);
        cyc();
        settle(); chk("bub_od_hold", 32'(od3), 32'h5A); chk("bub_ir_hold", 32'(ir3), 0);
        iv3 = 1'b0; or3 = 1'b1;
        settle(); chk("bub_rel_od", 32'(od3), 32'h5A);
        cyc();
        settle(); chk("bub_od_61", 32'(od3), 32'h61);
        cyc();
        settle(); chk("bub_od_62", 32'(od3), 32'h62);
        cyc();
        settle(); chk("bub_end_ov", 32'(ov3), 0); occ3("bub_end_occ", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
